// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32I multi-cycle core front end.
package rv32_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

   typedef enum logic [2:0] {
      REQ_IDLE = 3'd0,
      REQ      = 3'd1,
      WAIT     = 3'd2,
      EXEC     = 3'd3,
      HALTED   = 3'd4
   } fetch_state_t;

   // Instruction fetch targets must be word aligned.
   function automatic logic word_misaligned(input logic [1:0] addr_lsbs);
      return |addr_lsbs;
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC target selection; shared with the branch-trace logic.
module next_pc_calc
   import rv32_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] alu_result,
   input  logic            pc_src,
   input  logic            jalr_src,
   output logic [XLEN-1:0] target,
   output logic            target_misaligned
);

   always_comb begin
      target = pc + 32'd4;
      if (pc_src && jalr_src) begin
         target = alu_result & 32'hFFFF_FFFE;
      end else if (pc_src) begin
         target = pc + imm;
      end else begin
         target = pc + 32'd4;
      end
   end

   assign target_misaligned = word_misaligned(target[1:0]);

endmodule

// File: rtl/instr_fetch_sequencer.sv
// PC owner and single-outstanding instruction fetch FSM for the multi-cycle core.
// Optional retired-instruction counter enabled by defining FETCH_RETIRE_CNT_EN.
module instr_fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = rv32_pkg::RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic        pc_src,
   input  logic        jalr_src,
   input  logic        halt,
   input  logic [31:0] imm,
   input  logic [31:0] alu_result,
   output logic        halted,
   output logic        misaligned
`ifdef FETCH_RETIRE_CNT_EN
   ,output logic [63:0] retire_count
`endif
);

   import rv32_pkg::*;

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  instr_pc_q, instr_pc_d;
   logic         req_valid_q, req_valid_d;
   logic         instr_valid_q, instr_valid_d;
   logic         halted_q, halted_d;
   logic         misaligned_q, misaligned_d;
   logic [31:0]  target_s;
   logic         target_misaligned_s;
`ifdef FETCH_RETIRE_CNT_EN
   logic [63:0]  retire_q, retire_d;
`endif

   next_pc_calc u_next_pc_calc (
      .pc                (pc_q),
      .imm               (imm),
      .alu_result        (alu_result),
      .pc_src            (pc_src),
      .jalr_src          (jalr_src),
      .target            (target_s),
      .target_misaligned (target_misaligned_s)
   );

   // Next-state and registered-output computation for the fetch FSM.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      req_valid_d   = req_valid_q;
      instr_valid_d = instr_valid_q;
      halted_d      = halted_q;
      misaligned_d  = misaligned_q;
`ifdef FETCH_RETIRE_CNT_EN
      retire_d      = retire_q;
`endif
      case (state_q)
         REQ_IDLE: begin
            state_d     = REQ;
            req_valid_d = 1'b1;
         end
         REQ: begin
            if (imem_req_ready) begin
               req_valid_d = 1'b0;
               // Zero-latency memory: the response rides the handshake cycle.
               if (imem_rsp_valid) begin
                  instr_d       = imem_rsp_data;
                  instr_pc_d    = pc_q;
                  instr_valid_d = 1'b1;
                  state_d       = EXEC;
               end else begin
                  state_d = WAIT;
               end
            end else begin
               req_valid_d = 1'b1;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               instr_d       = imem_rsp_data;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               state_d       = EXEC;
            end else begin
               state_d = WAIT;
            end
         end
         EXEC: begin
            if (exec_done) begin
               instr_valid_d = 1'b0;
               if (halt) begin
                  halted_d = 1'b1;
                  state_d  = HALTED;
`ifdef FETCH_RETIRE_CNT_EN
                  retire_d = retire_q + 64'd1;
`endif
               end else if (target_misaligned_s) begin
                  misaligned_d = 1'b1;
                  halted_d     = 1'b1;
                  state_d      = HALTED;
               end else begin
                  pc_d        = target_s;
                  instr_d     = NOP_INSTR;
                  req_valid_d = 1'b1;
                  state_d     = REQ;
`ifdef FETCH_RETIRE_CNT_EN
                  retire_d    = retire_q + 64'd1;
`endif
               end
            end else begin
               state_d = EXEC;
            end
         end
         HALTED: begin
            req_valid_d   = 1'b0;
            instr_valid_d = 1'b0;
            halted_d      = 1'b1;
            state_d       = HALTED;
         end
         default: begin
            // An illegal encoding parks the core rather than fetching garbage.
            req_valid_d   = 1'b0;
            instr_valid_d = 1'b0;
            halted_d      = 1'b1;
            state_d       = HALTED;
         end
      endcase
   end

   // Fetch FSM state and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= REQ_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= NOP_INSTR;
         instr_pc_q    <= RESET_PC;
         req_valid_q   <= 1'b0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         misaligned_q  <= 1'b0;
`ifdef FETCH_RETIRE_CNT_EN
         retire_q      <= 64'd0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         req_valid_q   <= req_valid_d;
         instr_valid_q <= instr_valid_d;
         halted_q      <= halted_d;
         misaligned_q  <= misaligned_d;
`ifdef FETCH_RETIRE_CNT_EN
         retire_q      <= retire_d;
`endif
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_addr      = pc_q;
   assign instr          = instr_q;
   assign instr_pc       = instr_pc_q;
   assign instr_valid    = instr_valid_q;
   assign halted         = halted_q;
   assign misaligned     = misaligned_q;
`ifdef FETCH_RETIRE_CNT_EN
   assign retire_count   = retire_q;
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: directed vector table,
// hand-written corner sequences and randomized instructions against a reference model.
module tb_instr_fetch_sequencer;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'd0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        exec_done = 1'b0;
   logic        pc_src = 1'b0;
   logic        jalr_src = 1'b0;
   logic        halt = 1'b0;
   logic [31:0] imm = 32'd0;
   logic [31:0] alu_result = 32'd0;
   logic        halted;
   logic        misaligned;
`ifdef FETCH_RETIRE_CNT_EN
   logic [63:0] retire_count;
`endif

   instr_fetch_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .exec_done      (exec_done),
      .pc_src         (pc_src),
      .jalr_src       (jalr_src),
      .halt           (halt),
      .imm            (imm),
      .alu_result     (alu_result),
      .halted         (halted),
      .misaligned     (misaligned)
`ifdef FETCH_RETIRE_CNT_EN
      ,.retire_count  (retire_count)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state: architectural PC, sticky flags, retired count.
   logic [31:0] m_pc;
   logic        m_halt;
   logic        m_mis;
   logic [63:0] m_ret;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic randomize_steering();
      pc_src     = 1'($urandom_range(0, 1));
      jalr_src   = 1'($urandom_range(0, 1));
      halt       = 1'($urandom_range(0, 1));
      imm        = $urandom;
      alu_result = $urandom;
   endtask

   task automatic check_reset_values(input string tag);
      chk1({tag, "_req_valid"}, imem_req_valid, 1'b0);
      chk32({tag, "_addr"}, imem_addr, 32'h0);
      chk32({tag, "_instr"}, instr, NOP);
      chk32({tag, "_instr_pc"}, instr_pc, 32'h0);
      chk1({tag, "_instr_valid"}, instr_valid, 1'b0);
      chk1({tag, "_halted"}, halted, 1'b0);
      chk1({tag, "_misaligned"}, misaligned, 1'b0);
`ifdef FETCH_RETIRE_CNT_EN
      chk64({tag, "_retire"}, retire_count, 64'd0);
`endif
   endtask

   task automatic model_reset();
      m_pc   = 32'h0;
      m_halt = 1'b0;
      m_mis  = 1'b0;
      m_ret  = 64'd0;
   endtask

   // Holds reset for two cycles, checks reset values, then leaves the DUT in REQ.
   task automatic do_reset();
      rst            = 1'b1;
      exec_done      = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      model_reset();
      rst = 1'b0;
      @(negedge clk);
   endtask

   // One full instruction: request with backpressure, response latency, execute.
   task automatic do_instr(input int rdy_w, input int rsp_w, input int ex_w,
                           input logic [31:0] data, input logic ps, input logic js,
                           input logic hl, input logic [31:0] im, input logic [31:0] alu);
      logic [31:0] tgt;
      chk1("req_valid", imem_req_valid, 1'b1);
      chk32("req_addr", imem_addr, m_pc);
      for (int i = 0; i < rdy_w; i++) begin
         imem_req_ready = 1'b0;
         imem_rsp_valid = 1'($urandom_range(0, 1));
         imem_rsp_data  = $urandom;
         @(negedge clk);
         chk1("bp_req_valid", imem_req_valid, 1'b1);
         chk32("bp_addr", imem_addr, m_pc);
         chk1("bp_instr_valid", instr_valid, 1'b0);
      end
      imem_req_ready = 1'b1;
      if (rsp_w == 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = data;
         @(negedge clk);
         imem_req_ready = 1'b0;
         imem_rsp_valid = 1'b0;
      end else begin
         imem_rsp_valid = 1'b0;
         @(negedge clk);
         imem_req_ready = 1'b0;
         for (int i = 1; i < rsp_w; i++) begin
            chk1("wait_req_valid", imem_req_valid, 1'b0);
            @(negedge clk);
         end
         chk1("pre_rsp_instr_valid", instr_valid, 1'b0);
         chk1("pre_rsp_req_valid", imem_req_valid, 1'b0);
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = data;
         @(negedge clk);
         imem_rsp_valid = 1'b0;
      end
      chk1("fetch_instr_valid", instr_valid, 1'b1);
      chk32("fetch_instr", instr, data);
      chk32("fetch_instr_pc", instr_pc, m_pc);
      chk1("fetch_req_valid", imem_req_valid, 1'b0);
      for (int i = 0; i < ex_w; i++) begin
         exec_done = 1'b0;
         randomize_steering();
         imem_rsp_valid = 1'($urandom_range(0, 1));
         imem_rsp_data  = $urandom;
         @(negedge clk);
         chk1("exec_hold_valid", instr_valid, 1'b1);
         chk32("exec_hold_instr", instr, data);
      end
      imem_rsp_valid = 1'b0;
      exec_done  = 1'b1;
      pc_src     = ps;
      jalr_src   = js;
      halt       = hl;
      imm        = im;
      alu_result = alu;
      @(negedge clk);
      exec_done = 1'b0;
      randomize_steering();
      if (hl) begin
         m_halt = 1'b1;
         m_ret  = m_ret + 64'd1;
      end else begin
         if (!ps)     tgt = m_pc + 32'd4;
         else if (js) tgt = {alu[31:1], 1'b0};
         else         tgt = m_pc + im;
         if (tgt % 32'd4 != 32'd0) begin
            m_mis  = 1'b1;
            m_halt = 1'b1;
         end else begin
            m_pc  = tgt;
            m_ret = m_ret + 64'd1;
         end
      end
      chk1("done_instr_valid", instr_valid, 1'b0);
      chk1("done_halted", halted, m_halt);
      chk1("done_misaligned", misaligned, m_mis);
      chk1("done_req_valid", imem_req_valid, !m_halt);
      chk32("done_addr", imem_addr, m_pc);
      chk32("done_instr", instr, m_halt ? data : NOP);
`ifdef FETCH_RETIRE_CNT_EN
      chk64("retire", retire_count, m_ret);
`endif
   endtask

   // While halted, nothing on the inputs may restart fetching.
   task automatic check_stays_halted(input int n);
      for (int i = 0; i < n; i++) begin
         exec_done      = 1'($urandom_range(0, 1));
         imem_req_ready = 1'($urandom_range(0, 1));
         imem_rsp_valid = 1'($urandom_range(0, 1));
         imem_rsp_data  = $urandom;
         randomize_steering();
         @(negedge clk);
         chk1("halt_req_valid", imem_req_valid, 1'b0);
         chk1("halt_instr_valid", instr_valid, 1'b0);
         chk1("halt_halted", halted, 1'b1);
         chk32("halt_addr", imem_addr, m_pc);
      end
      exec_done      = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
   endtask

   typedef struct {
      int          rdy_w;
      int          rsp_w;
      logic        ps;
      logic        js;
      logic        hl;
      logic [31:0] im;
      logic [31:0] alu;
      logic [31:0] exp_next;
      logic        exp_halt;
      logic        exp_mis;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] data;
      logic [31:0] r_im;
      logic [31:0] r_alu;
      logic        r_ps;
      logic        r_js;
      logic        r_hl;

      tbl[0] = '{0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0004, 1'b0, 1'b0};
      tbl[1] = '{0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0008, 1'b0, 1'b0};
      tbl[2] = '{0, 1, 1'b1, 1'b0, 1'b0, 32'h8,         32'h0,         32'h0000_0010, 1'b0, 1'b0};
      tbl[3] = '{0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'h0000_0000, 1'b0, 1'b0};
      tbl[4] = '{3, 2, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_0021, 32'h0000_0020, 1'b0, 1'b0};
      tbl[5] = '{0, 0, 1'b1, 1'b1, 1'b0, 32'h4,         32'h0000_0101, 32'h0000_0100, 1'b0, 1'b0};
      tbl[6] = '{1, 1, 1'b1, 1'b1, 1'b0, 32'h0,         32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0, 1'b0};
      tbl[7] = '{0, 1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0000, 1'b0, 1'b0};
      tbl[8] = '{0, 0, 1'b1, 1'b0, 1'b0, 32'h6,         32'h0,         32'h0000_0000, 1'b1, 1'b1};

      model_reset();
      do_reset();

      for (int i = 0; i < 9; i++) begin
         data = 32'h00A0_0000 | 32'(i);
         do_instr(tbl[i].rdy_w, tbl[i].rsp_w, i % 3, data, tbl[i].ps, tbl[i].js,
                  tbl[i].hl, tbl[i].im, tbl[i].alu);
         chk32("tbl_next_addr", imem_addr, tbl[i].exp_next);
         chk1("tbl_halted", halted, tbl[i].exp_halt);
         chk1("tbl_misaligned", misaligned, tbl[i].exp_mis);
      end
      check_stays_halted(4);

      // Halt wins over a taken branch; PC must not move.
      do_reset();
      do_instr(0, 0, 1, 32'h0000_0073, 1'b1, 1'b0, 1'b1, 32'h40, 32'h80);
      chk32("halt_pc_kept", imem_addr, 32'h0);
      chk1("halt_not_misaligned", misaligned, 1'b0);
      check_stays_halted(4);

      // Reset in WAIT aborts the fetch; a late response after release is dropped.
      do_reset();
      do_instr(0, 0, 0, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      do_instr(0, 1, 0, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      chk1("wait_before_rst", imem_req_valid, 1'b0);
      rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      @(negedge clk);
      model_reset();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      rst = 1'b0;
      @(negedge clk);
      chk1("stale_rsp_instr_valid", instr_valid, 1'b0);
      chk32("stale_rsp_instr", instr, NOP);
      chk1("stale_rsp_req_valid", imem_req_valid, 1'b1);
      imem_rsp_valid = 1'b0;
      do_instr(0, 0, 0, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      // Randomized instructions against the reference model.
      for (int n = 0; n < 80; n++) begin
         if (m_halt) begin
            do_reset();
         end
         r_ps  = 1'($urandom_range(0, 1));
         r_js  = 1'($urandom_range(0, 1));
         r_hl  = ($urandom_range(0, 11) == 0);
         r_im  = 32'((int'($urandom_range(0, 127)) - 64) * 4);
         if ($urandom_range(0, 7) == 0) r_im[1:0] = 2'($urandom_range(1, 3));
         r_alu = $urandom & 32'hFFFF_FFFD;
         if ($urandom_range(0, 7) == 0) r_alu[1] = 1'b1;
         do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), $urandom, r_ps, r_js, r_hl, r_im, r_alu);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
Front end of the multi-cycle RV32I core. It owns the PC, fetches one instruction at a time from instruction memory over a valid/ready request and response interface, and presents the instruction to the control decoder. It then consumes the decoder's PC-steering outputs (pc_src, jalr_src, halt) to compute the next PC. Only one instruction is in flight at a time; there is no pipelining.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction value driven on instr while no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  core clock; all state changes on the rising edge.
rst  input  1  reset; asynchronous, active-high.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request.
imem_addr  output  32  fetch address; equals pc.
imem_rsp_valid  input  1  fetch data valid.
imem_rsp_data  input  32  fetched instruction word.
instr  output  32  instruction presented to the decoder and datapath.
instr_pc  output  32  PC of instr.
instr_valid  output  1  instr is valid and executing.
exec_done  input  1  core has finished instr; steering inputs are valid this cycle.
pc_src  input  1  take the branch or jump target.
jalr_src  input  1  target comes from alu_result (JALR).
halt  input  1  SYSTEM instruction; stop fetching.
imm  input  32  sign-extended immediate, used for PC-relative targets.
alu_result  input  32  JALR target before LSB clear.
halted  output  1  sticky; core is stopped.
misaligned  output  1  sticky; a halt was caused by a misaligned target.

Behaviour:
- Reset (async, active-high) values:
  - state=REQ_IDLE, pc=RESET_PC, imem_req_valid=0.
  - instr=NOP_INSTR, instr_pc=RESET_PC, instr_valid=0.
  - halted=0, misaligned=0.
- FSM states: REQ_IDLE, REQ, WAIT, EXEC, HALTED.
- REQ_IDLE: one cycle after reset is released, then go to REQ. This cycle absorbs reset deassertion.
- REQ:
  - imem_req_valid=1 and imem_addr=pc, both held stable until imem_req_ready=1.
  - On handshake, go to WAIT.
  - If imem_rsp_valid=1 in the handshake cycle (zero-latency memory), capture the data and go directly to EXEC.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid=1: instr<=imem_rsp_data, instr_pc<=pc, go to EXEC.
- imem_rsp_valid outside WAIT and outside the REQ handshake cycle is ignored.
- EXEC:
  - instr_valid=1; instr and instr_pc are held stable.
  - exec_done=0: stay in EXEC.
  - exec_done=1, next-PC priority:
    - halt=1: go to HALTED. pc is unchanged; pc_src is ignored.
    - pc_src=1 & jalr_src=1: target = alu_result & ~32'h1.
    - pc_src=1 & jalr_src=0: target = pc + imm (mod 2^32).
    - otherwise: target = pc + 4 (wrap from 32'hFFFF_FFFC to 0).
  - If target[1:0] != 0: misaligned<=1, go to HALTED, pc unchanged.
  - Else: pc<=target, instr<=NOP_INSTR, go to REQ.
  - instr_valid deasserts the cycle after exec_done.
- HALTED:
  - instr_valid=0, imem_req_valid=0, halted=1.
  - Exit only through rst.
- Steering inputs (pc_src, jalr_src, halt, imm, alu_result) are sampled only when exec_done=1 in EXEC; they are don't-care otherwise.
- Latency with zero-wait memory (ready=1, rsp in the same cycle): instr_valid rises 1 cycle after entering REQ. With rsp one cycle after the handshake: 2 cycles.
- Reset asserted mid-fetch or mid-execution aborts immediately. Any late imem_rsp arriving after reset is ignored because the FSM is in REQ_IDLE.

Optional Feature:
- Macro: FETCH_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_count, 64 bits, reset to 0.
  - Increments by 1 on every exec_done in EXEC that does not end in HALTED via misalignment.
  - A halt instruction does count.
  - Wraps modulo 2^64.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package rv32_pkg holds:
  - the FSM state enum (fetch_state_t);
  - the constants RESET_PC_DEFAULT, NOP_INSTR and XLEN=32.
- One sub-module, next_pc_calc: combinational; takes pc, imm, alu_result, pc_src and jalr_src; produces target and target_misaligned. It is reused by the branch-trace logic.

Test Plan:
- Sequential fetch: reset, memory always ready with rsp in the same cycle, exec_done pulsed with pc_src=0 → imem_addr sequence 0x0, 0x4, 0x8; instr_pc tracks the address.
- Branch taken: at pc=0x10, exec_done with pc_src=1, jalr_src=0, imm=0xFFFFFFF0 → next imem_addr=0x0.
- JALR: at pc=0x20, exec_done with pc_src=1, jalr_src=1, alu_result=0x101 → next imem_addr=0x100.
- Misaligned: at pc=0x0, pc_src=1, jalr_src=0, imm=0x6 → misaligned=1, halted=1, no further imem_req_valid, pc=0x0.
- Backpressure and latency: imem_req_ready low for 3 cycles, then rsp 2 cycles after the handshake → imem_addr stable throughout; instr_valid rises exactly 1 cycle after rsp_valid.
- Halt and reset: exec_done with halt=1 and pc_src=1 → HALTED, pc not updated. Then assert rst mid-WAIT on a later run → all outputs return to reset values immediately, and the stale rsp is ignored.
